// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes and memory-port control lines shared by the two-master
// memory arbiter; the bidirectional data bus stays a plain port on the arbiter.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32
);
  logic                    req0, req1;
  logic                    rnw0, rnw1;
  logic [ADDRESS_SIZE-1:0] addr0, addr1;
  logic [WORD_SIZE-1:0]    wdata0, wdata1;
  logic                    ack0, ack1;
  logic                    err0, err1;
  logic [WORD_SIZE-1:0]    rdata0, rdata1;
  logic                    mem_en;
  logic                    mem_rnw;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic                    mem_ready;
  logic                    busy;
  logic                    gnt;

  modport slave (
    input  req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, mem_ready,
    output ack0, ack1, err0, err1, rdata0, rdata1, mem_en, mem_rnw, mem_addr, busy, gnt
  );

  modport master (
    output req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, mem_ready,
    input  ack0, ack1, err0, err1, rdata0, rdata1, mem_en, mem_rnw, mem_addr, busy, gnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one level-ready memory port between two req/ack
// masters, with a minimum-latency guard and a timeout error completion.
//
// state  | meaning
// IDLE   | bus released, pick a winner among pending requests
// ACCESS | ENABLE high, waiting for DATA_READY or timeout
// DONE   | one-cycle ack/err pulse to the winner, ENABLE low
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int MIN_LAT      = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  inout  wire [WORD_SIZE-1:0]  mem_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic                    last_grant_q, gnt_q, rnw_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic                    ack0_q, ack1_q, err0_q, err1_q;
  logic [WORD_SIZE-1:0]    rdata0_q, rdata1_q;
  logic                    any_req, win;
  logic                    ready_hit, timeout_hit, done_hit;
  logic                    mem_en_c, busy_c, drive_c;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;
  end

  // DATA_READY is a level, so it is only trusted after MIN_LAT enabled cycles
  assign ready_hit   = (cnt_q >= CW'(MIN_LAT)) && bus.mem_ready;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT));
  assign done_hit    = ready_hit | timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (done_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_c = (state_q == ACCESS);
    busy_c   = (state_q == ACCESS) || (state_q == DONE);
    drive_c  = (state_q == ACCESS) && !rnw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      rnw_q        <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q        <= win;
            last_grant_q <= win;
            rnw_q        <= win ? bus.rnw1   : bus.rnw0;
            addr_q       <= win ? bus.addr1  : bus.addr0;
            wdata_q      <= win ? bus.wdata1 : bus.wdata0;
            cnt_q        <= '0;
          end
        end
        ACCESS: begin
          if (!timeout_hit) cnt_q <= cnt_q + CW'(1);
          if (done_hit) begin
            if (gnt_q) begin
              ack1_q <= 1'b1;
              err1_q <= ~ready_hit;
              if (ready_hit && rnw_q) rdata1_q <= mem_data;
            end else begin
              ack0_q <= 1'b1;
              err0_q <= ~ready_hit;
              if (ready_hit && rnw_q) rdata0_q <= mem_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_data     = drive_c ? wdata_q : 'z;
  assign bus.mem_en   = mem_en_c;
  assign bus.busy     = busy_c;
  assign bus.mem_rnw  = rnw_q;
  assign bus.mem_addr = addr_q;
  assign bus.gnt      = gnt_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.err0     = err0_q;
  assign bus.err1     = err1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one read/write test-bench memory port between the DLX data-memory side and a second master, such as a loader or checker. Each requester uses a simple req/ack handshake. The arbiter grants round-robin, drives the memory's ENABLE / READNOTWRITE / ADDRESS / INOUT_DATA lines, and waits out the memory's data delay. It then returns read data or write completion to the winner, with a timeout error if DATA_READY never arrives.

## Interface
- WORD_SIZE, 32, data width in bits
- ADDRESS_SIZE, 32, address width in bits
- MIN_LAT, 1, minimum ENABLE-high cycles before DATA_READY is trusted (memory DATA_READY is level, not a pulse)
- TIMEOUT, 16, max ENABLE-high cycles before forced error completion; must be > MIN_LAT
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0, req1  in  1  request, held until matching ack
- rnw0, rnw1  in  1  1 = read, 0 = write; stable while req
- addr0, addr1  in  ADDRESS_SIZE  byte address; stable while req
- wdata0, wdata1  in  WORD_SIZE  write data; stable while req
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  valid with ack; 1 = timeout
- rdata0, rdata1  out  WORD_SIZE  read data, valid with ack, held until next own read ack
- mem_en  out  1  memory ENABLE
- mem_rnw  out  1  memory READNOTWRITE
- mem_addr  out  ADDRESS_SIZE  memory ADDRESS
- mem_data  inout  WORD_SIZE  memory INOUT_DATA; driven only during a granted write, else 'Z
- mem_ready  in  1  memory DATA_READY
- busy  out  1  high in ACCESS or DONE
- gnt  out  1  index of current/last granted requester

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay; mem_en = 0.
  - One req: grant it.
  - Both req: grant the index != last_grant.
  - On grant: latch rnw/addr/wdata of winner into internal regs, set gnt and last_grant, clear cnt, go ACCESS.
- ACCESS:
  - mem_en = 1; mem_rnw/mem_addr come from latched regs.
  - mem_data = latched wdata when write, 'Z when read.
  - cnt increments each cycle, saturating at TIMEOUT.
  - If cnt >= MIN_LAT and mem_ready: capture mem_data into the winner's rdata (reads only; writes leave rdata unchanged), err = 0, go DONE.
  - Else if cnt == TIMEOUT: err = 1, rdata unchanged, go DONE.
  - Ready has priority over timeout in the same cycle.
- DONE:
  - mem_en = 0, mem_data = 'Z.
  - ack[gnt] = 1 for this cycle only; err[gnt] = stored error.
  - Go IDLE unconditionally. The guaranteed idle cycle lets the memory see ENABLE fall between transactions.
- Requester dropping req during ACCESS: ignored; the transaction completes and ack still pulses.
- Requester keeping req high after its ack: treated as a new request in IDLE; round-robin gives the other port priority if it is requesting.
- Latched inputs are not re-sampled during ACCESS; requester changes mid-transaction have no effect.
- No address range checking; out-of-range behaviour belongs to the memory.

## Timing
- Reset (rst low, asynchronous): FSM = IDLE, cnt = 0, last_grant = 1 (port 0 wins first tie), gnt = 0.
  - Outputs: ack0/1 = 0, err0/1 = 0, rdata0/1 = 0, mem_en = 0, mem_rnw = 1, mem_addr = 0, mem_data = 'Z, busy = 0.
- Reset asserted mid-ACCESS: bus released immediately (mem_en = 0, mem_data = 'Z), no ack issued, pending transaction lost.
- Cycle numbering for req sampled high in IDLE at cycle N, with MIN_LAT = 1 and memory ready after 1 cycle:
  - mem_en high in cycles N+1 and N+2.
  - Read data captured at end of N+2.
  - ack and rdata valid in N+3.
  - Earliest next grant decision in N+4, so mem_en rises again in N+5.
- Minimum req-to-ack latency: MIN_LAT + 2 cycles.
- Maximum req-to-ack latency when granted immediately: TIMEOUT + 2 cycles.
- Write data is presented on mem_data for the whole ACCESS period.
- ack, err and rdata are registered outputs.
- mem_* outputs are registered or decoded from state only; no combinational path from req* to mem_*.

## Test plan
- Reset values: hold rst low 3 cycles -> every output at its listed reset value, mem_data = 'Z. Release rst with no req -> mem_en stays 0.
- Single read: port 0 reads 0x10, memory returns 0xDEADBEEF -> ack0 exactly 3 cycles after req0 sampled, rdata0 = 0xDEADBEEF, err0 = 0, ack1 never pulses.
- Single write then readback: port 1 writes 0xCAFEF00D at 0x20 -> mem_data = 0xCAFEF00D while mem_en high, ack1 pulses. Port 1 then reads 0x20 -> rdata1 = 0xCAFEF00D.
- Contention: req0 and req1 rise together and stay high -> grants alternate 0,1,0,1. Each ack lands only on the granted port, and mem_en is low for at least 1 cycle between transactions.
- Timeout: mem_ready tied 0, port 0 read, TIMEOUT = 16 -> ack0 with err0 = 1 exactly 18 cycles after req0 sampled, rdata0 unchanged. FSM then returns to IDLE and serves port 1 normally.
- Async reset mid-ACCESS: assert rst during ACCESS, off a clock edge -> mem_en falls and mem_data goes 'Z without waiting for clk, no ack. After release, a fresh port 0 read completes normally.
